// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce, auto-repeat and latch active-low push-buttons
module button_conditioner #(
  parameter int               N_BTN           = 3,
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_RATE     = 6250000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             tick,
  output logic [N_BTN-1:0] evt_n,
  output logic [N_BTN-1:0] held_n,
  output logic [N_BTN-1:0] dropped
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_RATE - 1);
  localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);

  // Synchroniser stages and debounced level; 1 means released.
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] db_q, db_d;
  logic [DB_W-1:0]  db_cnt_q [N_BTN];
  logic [DB_W-1:0]  db_cnt_d [N_BTN];
  // Auto-repeat counter; phase 0 waits for the initial delay, phase 1 for the rate.
  logic [RP_W-1:0]  rp_cnt_q [N_BTN];
  logic [RP_W-1:0]  rp_cnt_d [N_BTN];
  logic [N_BTN-1:0] rp_phase_q, rp_phase_d;
  // Event handshake with the game core.
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] drop_q, drop_d;
  logic [N_BTN-1:0] evt;

  // Next-state logic: debounce, press/repeat event generation, pending latch.
  always_comb begin
    sync1_d    = btn_n;
    sync2_d    = sync1_q;
    db_d       = db_q;
    db_cnt_d   = db_cnt_q;
    rp_cnt_d   = rp_cnt_q;
    rp_phase_d = rp_phase_q;
    evt        = '0;
    for (int i = 0; i < N_BTN; i++) begin
      // Level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]     = ~db_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end else begin
        db_cnt_d[i] = '0;
      end

      if (db_q[i] && !db_d[i]) begin
        // Press edge: one event and restart the repeat timing.
        evt[i]        = 1'b1;
        rp_cnt_d[i]   = '0;
        rp_phase_d[i] = 1'b0;
      end else if (!db_q[i] && !db_d[i] && REPEAT_MASK[i]) begin
        // Still held on a repeating channel; a release edge falls to the clear branch.
        if (rp_cnt_q[i] == (rp_phase_q[i] ? RP_NEXT : RP_FIRST)) begin
          evt[i]        = 1'b1;
          rp_cnt_d[i]   = '0;
          rp_phase_d[i] = 1'b1;
        end else begin
          rp_cnt_d[i] = rp_cnt_q[i] + RP_ONE;
        end
      end else begin
        rp_cnt_d[i]   = '0;
        rp_phase_d[i] = 1'b0;
      end
    end
    // A new event always wins over a tick in the same cycle; events never queue.
    pend_d = evt | (pend_q & ~{N_BTN{tick}});
    drop_d = drop_q | (evt & pend_q & ~{N_BTN{tick}});
  end

  // State registers with asynchronous active-low reset to the released/idle state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      db_q       <= '1;
      rp_phase_q <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= '0;
        rp_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      rp_phase_q <= rp_phase_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        rp_cnt_q[i] <= rp_cnt_d[i];
      end
    end
  end

  assign evt_n   = ~pend_q;
  assign held_n  = db_q;
  assign dropped = drop_q;

endmodule
